// File: rtl/chip8_pkg.sv
// Opcode enumeration shared by the stream decoder and the execute FSM.
// Value 0 is reserved for illegal encodings.
package chip8_pkg;
  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ILL       = 6'd0,
    OP_CLS       = 6'd1,
    OP_RET       = 6'd2,
    OP_JP        = 6'd3,
    OP_CALL      = 6'd4,
    OP_SE_VAL    = 6'd5,
    OP_SNE_VAL   = 6'd6,
    OP_SE_VXVY   = 6'd7,
    OP_LD_VAL    = 6'd8,
    OP_ADD_VAL   = 6'd9,
    OP_LD_VXVY   = 6'd10,
    OP_OR        = 6'd11,
    OP_AND       = 6'd12,
    OP_XOR       = 6'd13,
    OP_ADD_VXVY  = 6'd14,
    OP_SUB       = 6'd15,
    OP_SHR       = 6'd16,
    OP_SUBN      = 6'd17,
    OP_SHL       = 6'd18,
    OP_SNE_VXVY  = 6'd19,
    OP_LD_I      = 6'd20,
    OP_JP_V0     = 6'd21,
    OP_RND       = 6'd22,
    OP_DRW       = 6'd23,
    OP_SKP       = 6'd24,
    OP_SKNP      = 6'd25,
    OP_LD_VX_DT  = 6'd26,
    OP_LD_VX_K   = 6'd27,
    OP_LD_DT     = 6'd28,
    OP_LD_ST     = 6'd29,
    OP_ADD_I     = 6'd30,
    OP_LD_F      = 6'd31,
    OP_LD_B      = 6'd32,
    OP_LD_MEM_I  = 6'd33,
    OP_LD_VX_MEM = 6'd34,
    OP_SCD       = 6'd35,
    OP_SCR       = 6'd36,
    OP_SCL       = 6'd37,
    OP_EXIT      = 6'd38,
    OP_LOW       = 6'd39,
    OP_HIGH      = 6'd40,
    OP_DRW16     = 6'd41,
    OP_LD_HF     = 6'd42,
    OP_LD_R      = 6'd43,
    OP_LD_VR     = 6'd44
  } op_e;
endpackage

// File: rtl/decode_stream_lut.sv
// Combinational CHIP-8 / SUPER-CHIP opcode classifier.
module decode_lut
  import chip8_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        schip_en,
  output op_e         op,
  output logic        illegal
);
  logic [3:0] nib;
  logic [7:0] kk;
  assign nib = instr[3:0];
  assign kk  = instr[7:0];

  always_comb begin
    op = OP_ILL;
    case (instr[15:12])
      4'h0: begin
        if (instr == 16'h00E0)      op = OP_CLS;
        else if (instr == 16'h00EE) op = OP_RET;
        else if (schip_en) begin
          if (instr[15:4] == 12'h00C) op = OP_SCD;
          else begin
            case (instr)
              16'h00FB: op = OP_SCR;
              16'h00FC: op = OP_SCL;
              16'h00FD: op = OP_EXIT;
              16'h00FE: op = OP_LOW;
              16'h00FF: op = OP_HIGH;
              default:  op = OP_ILL;
            endcase
          end
        end
      end
      4'h1: op = OP_JP;
      4'h2: op = OP_CALL;
      4'h3: op = OP_SE_VAL;
      4'h4: op = OP_SNE_VAL;
      4'h5: if (nib == 4'h0) op = OP_SE_VXVY;
      4'h6: op = OP_LD_VAL;
      4'h7: op = OP_ADD_VAL;
      4'h8: begin
        // ALU group is contiguous 10..17 for nibbles 0..7
        if (nib <= 4'h7)       op = op_e'(6'd10 + {2'b00, nib});
        else if (nib == 4'hE)  op = OP_SHL;
      end
      4'h9: if (nib == 4'h0) op = OP_SNE_VXVY;
      4'hA: op = OP_LD_I;
      4'hB: op = OP_JP_V0;
      4'hC: op = OP_RND;
      4'hD: op = (schip_en && nib == 4'h0) ? OP_DRW16 : OP_DRW;
      4'hE: begin
        if (kk == 8'h9E)      op = OP_SKP;
        else if (kk == 8'hA1) op = OP_SKNP;
      end
      4'hF: begin
        case (kk)
          8'h07: op = OP_LD_VX_DT;
          8'h0A: op = OP_LD_VX_K;
          8'h15: op = OP_LD_DT;
          8'h18: op = OP_LD_ST;
          8'h1E: op = OP_ADD_I;
          8'h29: op = OP_LD_F;
          8'h33: op = OP_LD_B;
          8'h55: op = OP_LD_MEM_I;
          8'h65: op = OP_LD_VX_MEM;
          8'h30: if (schip_en) op = OP_LD_HF;
          8'h75: if (schip_en) op = OP_LD_R;
          8'h85: if (schip_en) op = OP_LD_VR;
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  assign illegal = (op == OP_ILL);
endmodule

// File: rtl/decode_stream.sv
// Byte-stream to 16-bit instruction assembler with registered decode output
// and a valid/ready handshake toward the execute stage.
module decode_stream
  import chip8_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter bit SCHIP_EN = 1'b0,
  parameter int OP_W     = chip8_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   op,
  output logic              illegal,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic [3:0]        nib,
  output logic [7:0]        val,
  output logic [11:0]       addr
);
  typedef enum logic [1:0] {ST_HI, ST_LO, ST_OUT} st_e;

  st_e               state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] hi_pc;
  logic [7:0]        hi;
  logic              acc;
  op_e               lut_op;
  logic              lut_ill;

  // In ST_OUT a new high byte may only enter alongside the output handshake.
  assign in_ready = ~flush & ((state != ST_OUT) | out_ready);
  assign acc      = in_valid & in_ready;

  decode_lut u_lut (
    .instr    ({hi, in_byte}),
    .schip_en (SCHIP_EN),
    .op       (lut_op),
    .illegal  (lut_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HI;
      pc        <= '0;
      hi        <= '0;
      hi_pc     <= '0;
      out_valid <= 1'b0;
      op        <= '0;
      illegal   <= 1'b0;
      instr     <= '0;
      instr_pc  <= '0;
    end else if (flush) begin
      state     <= ST_HI;
      out_valid <= 1'b0;
      pc        <= flush_pc;
    end else begin
      case (state)
        ST_HI: if (acc) begin
          hi    <= in_byte;
          hi_pc <= pc;
          pc    <= pc + ADDR_W'(1);
          state <= ST_LO;
        end
        ST_LO: if (acc) begin
          instr     <= {hi, in_byte};
          instr_pc  <= hi_pc;
          op        <= OP_W'(lut_op);
          illegal   <= lut_ill;
          out_valid <= 1'b1;
          pc        <= pc + ADDR_W'(1);
          state     <= ST_OUT;
        end
        ST_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (acc) begin
            hi    <= in_byte;
            hi_pc <= pc;
            pc    <= pc + ADDR_W'(1);
            state <= ST_LO;
          end else begin
            state <= ST_HI;
          end
        end
        default: state <= ST_HI;
      endcase
    end
  end

  assign x    = instr[11:8];
  assign y    = instr[7:4];
  assign nib  = instr[3:0];
  assign val  = instr[7:0];
  assign addr = instr[11:0];
endmodule
